// File: rtl/prio_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : prio_grant_arbiter
// Brief    : Eight-requester single-resource arbiter. The highest-numbered
//            active request wins (8-to-3 priority-encoder order). The grant
//            is held until the owner releases it with done, withdraws its
//            request, or exceeds MAX_HOLD consecutive cycles. In the last
//            case the grant is revoked and a one-cycle revoked pulse follows.
//            Compile-time macro ARB_ROUND_ROBIN_EN switches to a rotating
//            search order that makes the last owner the lowest priority.
// Revision : 1.0 - initial release
// ============================================================================
module prio_grant_arbiter #(
    // Maximum consecutive grant cycles before a forced revoke. 0 disables it.
    parameter int MAX_HOLD = 16,
    // Hold-counter width. MAX_HOLD must fit, i.e. MAX_HOLD <= 2**HOLD_W - 1.
    parameter int HOLD_W   = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic       done,
    output logic [7:0] gnt,
    output logic [2:0] gnt_id,
    output logic       gnt_valid,
    output logic       revoked
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    localparam logic [HOLD_W-1:0] c_MAX_HOLD   = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] c_CNT_SAT    = '1;
    localparam logic              c_TIMEOUT_EN = (MAX_HOLD != 0);

    state_t            r_state;
    logic [2:0]        r_own;
    logic [HOLD_W-1:0] r_cnt;

    state_t            w_state_nxt;
    logic [2:0]        w_own_nxt;
    logic [HOLD_W-1:0] w_cnt_nxt;
    logic [7:0]        w_gnt_nxt;
    logic [2:0]        w_gnt_id_nxt;
    logic              w_gnt_valid_nxt;
    logic              w_revoked_nxt;
    logic [2:0]        w_win_id;
    logic              w_release;

`ifdef ARB_ROUND_ROBIN_EN
    // The rotation pointer only influences anything when rotation is enabled.
    logic [2:0]        r_ptr;
    logic [2:0]        w_ptr_nxt;
    logic [2:0]        w_rr_idx;

    // Rotating winner: search ptr-1, ptr-2, ... down to ptr; the later loop
    // iterations overwrite earlier ones, so k = 0 (ptr-1) is the strongest.
    always_comb begin
        w_win_id = 3'd0;
        w_rr_idx = 3'd0;
        for (int k = 7; k >= 0; k--) begin
            w_rr_idx = r_ptr - 3'd1 - 3'(k);
            if (req[w_rr_idx]) begin
                w_win_id = w_rr_idx;
            end
        end
    end
`else
    // Fixed winner: highest set bit of req, scanned upward so it lands last.
    always_comb begin
        w_win_id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (req[i]) begin
                w_win_id = 3'(i);
            end
        end
    end
`endif

    // Next-state and next-output logic; release precedence is done, then
    // owner withdrawal, then timeout, so a coincident done never revokes.
    always_comb begin
        w_state_nxt     = r_state;
        w_own_nxt       = r_own;
        w_cnt_nxt       = r_cnt;
        w_gnt_nxt       = gnt;
        w_gnt_id_nxt    = gnt_id;
        w_gnt_valid_nxt = gnt_valid;
        w_revoked_nxt   = 1'b0;
        w_release       = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        w_ptr_nxt       = r_ptr;
`endif
        case (r_state)
            S_IDLE: begin
                w_gnt_nxt       = 8'd0;
                w_gnt_id_nxt    = 3'd0;
                w_gnt_valid_nxt = 1'b0;
                if (|req) begin
                    w_state_nxt     = S_GRANT;
                    w_own_nxt       = w_win_id;
                    w_cnt_nxt       = HOLD_W'(1);
                    w_gnt_nxt       = 8'(1) << w_win_id;
                    w_gnt_id_nxt    = w_win_id;
                    w_gnt_valid_nxt = 1'b1;
                end
            end
            S_GRANT: begin
                if (done || !req[r_own]) begin
                    w_release = 1'b1;
                end else if (c_TIMEOUT_EN && (r_cnt == c_MAX_HOLD)) begin
                    w_release     = 1'b1;
                    w_revoked_nxt = 1'b1;
                end else if (r_cnt != c_CNT_SAT) begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_release = 1'b1;
            end
        endcase

        if (w_release) begin
            w_state_nxt     = S_IDLE;
            w_gnt_nxt       = 8'd0;
            w_gnt_id_nxt    = 3'd0;
            w_gnt_valid_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            w_ptr_nxt       = r_own;
`endif
        end
    end

    // State, owner, hold counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_own     <= 3'd0;
            r_cnt     <= '0;
            gnt       <= 8'd0;
            gnt_id    <= 3'd0;
            gnt_valid <= 1'b0;
            revoked   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_own     <= w_own_nxt;
            r_cnt     <= w_cnt_nxt;
            gnt       <= w_gnt_nxt;
            gnt_id    <= w_gnt_id_nxt;
            gnt_valid <= w_gnt_valid_nxt;
            revoked   <= w_revoked_nxt;
        end
    end

`ifdef ARB_ROUND_ROBIN_EN
    // Rotation pointer: remembers the most recent owner after each release.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 3'd0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_prio_grant_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_prio_grant_arbiter
// Brief    : Directed, table-driven bench for prio_grant_arbiter (MAX_HOLD=4).
//            Each record gives inputs applied before a rising edge and the
//            outputs expected just after it. A hand-written rotation sequence
//            follows; its expectations depend on ARB_ROUND_ROBIN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prio_grant_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] gnt_id;
    logic       gnt_valid;
    logic       revoked;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic       done;
        logic [7:0] gnt;
        logic [2:0] id;
        logic       valid;
        logic       rev;
    } vec_t;

    vec_t vecs[$];

    prio_grant_arbiter #(
        .MAX_HOLD (4),
        .HOLD_W   (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .revoked   (revoked)
    );

    always #5 clk = ~clk;

    task automatic v(input logic r, input logic [7:0] rq, input logic d,
                     input logic [7:0] g, input logic [2:0] i,
                     input logic vl, input logic rv);
        vecs.push_back('{r, rq, d, g, i, vl, rv});
    endtask

    task automatic check(input string name, input logic [7:0] eg,
                         input logic [2:0] ei, input logic ev, input logic er);
        n_tests++;
        if (gnt !== eg || gnt_id !== ei || gnt_valid !== ev || revoked !== er) begin
            n_fail++;
            $display("FAIL %s: got gnt=%h id=%0d valid=%b rev=%b, want gnt=%h id=%0d valid=%b rev=%b",
                     name, gnt, gnt_id, gnt_valid, revoked, eg, ei, ev, er);
        end
    endtask

    initial begin
        logic [2:0] exp_id;

        //  rst  req    done  gnt    id    vld   rev
        // reset with all requests pending, then owner 7 right after release
        v(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b1, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'hFF, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        v(1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        // fixed priority: 2C -> 5, done in 3rd grant cycle, then 0C -> 3
        v(1'b0, 8'h2C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        v(1'b0, 8'h2C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        v(1'b0, 8'h2C, 1'b0, 8'h20, 3'd5, 1'b1, 1'b0);
        v(1'b0, 8'h0C, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h0C, 1'b0, 8'h08, 3'd3, 1'b1, 1'b0);
        v(1'b0, 8'h0C, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        // timeout: four grant cycles, revoke pulse, immediate re-grant
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        // done coinciding with the timeout cycle is a normal release
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        // owner withdraws its request mid-grant
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0);
        v(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        // higher request from a non-owner does not preempt
        v(1'b0, 8'h01, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        v(1'b0, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0);
        v(1'b0, 8'h80, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h80, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        v(1'b0, 8'h80, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        // reset in grant cycle 2 of owner 4, then 90 -> 7
        v(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
        v(1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0);
        v(1'b1, 8'h10, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h90, 1'b0, 8'h80, 3'd7, 1'b1, 1'b0);
        v(1'b0, 8'h90, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0);
        v(1'b0, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);

        for (int n = 0; n < vecs.size(); n++) begin
            rst  = vecs[n].rst;
            req  = vecs[n].req;
            done = vecs[n].done;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", n), vecs[n].gnt, vecs[n].id,
                  vecs[n].valid, vecs[n].rev);
        end

        // Rotation: all requesting, done in each owner's first grant cycle.
        rst  = 1'b1;
        req  = 8'hFF;
        done = 1'b0;
        @(posedge clk);
        #1;
        check("rr_reset", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_id = 3'(7 - i);
`else
            exp_id = 3'd7;
`endif
            @(posedge clk);
            #1;
            check($sformatf("rr_grant%0d", i), 8'(1) << exp_id, exp_id, 1'b1, 1'b0);
            done = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("rr_gap%0d", i), 8'h00, 3'd0, 1'b0, 1'b0);
            done = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
